instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
// - Upstream neighbour of the controller FSM: holds the program counter (PC) and instruction register (IR).
// - Drives the instruction-memory address and captures the returned word on IRLd.
// - Presents the held IR as the controller's 16-bit instruction input.
// - Obeys the controller strobes PCClr, PCUp and IRLd; adds PCLd (absolute jump) and a debug fetch counter.
// PARAMETERS
// - PC_WIDTH     7   PC / instruction-memory address width (128 words)
// - INSTR_WIDTH  16  instruction word width
// - CNT_WIDTH    16  width of the saturating fetch counter
// PORTS
// - Clk        in   1            single clock, rising edge
// - Rst        in   1            synchronous, active-high reset
// - PCClr      in   1            clear PC to 0 (controller INIT state)
// - PCUp       in   1            PC <= PC+1 (controller FETCH state)
// - PCLd       in   1            PC <= PCLdValue (jump; reserved for future opcodes)
// - PCLdValue  in   PC_WIDTH     jump target
// - IRLd       in   1            capture ImemData into IR
// - ImemData   in   INSTR_WIDTH  instruction memory read data, combinational from ImemAddr
// - ImemAddr   out  PC_WIDTH     instruction memory address, equals PC
// - PCOut      out  PC_WIDTH     current PC (debug/display)
// - IR         out  INSTR_WIDTH  held instruction, feeds controller 'instruction'
// - IRPC       out  PC_WIDTH     address the held IR was fetched from
// - IRValid    out  1            IR holds a word loaded since the last reset or clear
// - FetchCount out  CNT_WIDTH    number of IRLd events, saturating
// BEHAVIOUR
// - Rst=1 at a rising edge sets PC=0, IR=0, IRPC=0, IRValid=0 and FetchCount=0 at that edge.
//   - Rst dominates every other input.
//   - Mid-operation reset discards the IR contents; no partial update occurs.
// - PC update priority per edge: Rst > PCClr > PCLd > PCUp > hold.
//   - PCUp at PC=2^PC_WIDTH-1 wraps to 0. There is no flag and no stall.
// - ImemAddr = PC, combinational. It is the PC value before this edge's update.
// - IRLd=1 at an edge:
//   - IR <= ImemData, IRPC <= PC (pre-update value), IRValid <= 1.
//   - FetchCount increments, holding at all-ones.
// - IRLd and PCUp asserted together (the normal FETCH cycle): IR takes the word at the OLD PC while PC advances.
//   - Result: after FETCH, IR=mem[n] and PC=n+1.
// - IRLd together with PCClr: IR and IRPC still load from the old PC, and PC goes to 0.
//   - IRValid is forced to 0, because a clear marks a program restart.
// - IR, IRPC and IRValid hold whenever IRLd=0. The controller decodes IR in DECODE and executes in later cycles.
//   - IR must stay stable across all of those cycles.
// - Latency: the new IR is visible the cycle after IRLd, so it is ready when the controller is in DECODE.
// - No handshake with the memory. ImemData must settle within one cycle of an ImemAddr change.
// - All outputs are registered except ImemAddr and PCOut, which are direct copies of the PC register.
// STRUCTURE
// - Shared package cpu_pkg:
//   - PC_WIDTH and INSTR_WIDTH constants.
//   - typedef logic [PC_WIDTH-1:0] pc_t, typedef logic [INSTR_WIDTH-1:0] instr_t.
//   - opcode field slice constants OPC_MSB=15, OPC_LSB=12.
//   - The controller also imports this package.
// - One sub-module, pc_register: PC with the clear/load/increment priority and wrap-around.
//   - The top level holds the IR, IRPC, IRValid and FetchCount registers.
// TESTING
// - Reset: Rst=1 for 2 cycles with PCUp=1 and IRLd=1 held.
//   - Expect PC=0, IR=0, IRValid=0, FetchCount=0.
// - Fetch sequence: memory holds mem[0]=16'h2A13 and mem[1]=16'h3124. Pulse IRLd+PCUp, idle 2 cycles, pulse again.
//   - After the first pulse: IR=2A13, IRPC=0, PC=1.
//   - After the second: IR=3124, IRPC=1, PC=2, FetchCount=2.
// - Wrap: PCLd with 7'h7F, then PCUp.
//   - Expect PC=0x00. IRLd on the same edge gives IRPC=0x7F.
// - Priority: assert PCClr, PCLd(0x10) and PCUp together.
//   - Expect PC=0. Then PCLd(0x10)+PCUp gives PC=0x10.
// - Mid-run reset: Rst=1 during a cycle where IRLd=1 and IR=2A13.
//   - Expect IR=0 and IRValid=0 the next cycle, and FetchCount=0.
// - Saturation with CNT_WIDTH=4: apply 20 IRLd pulses.
//   - Expect FetchCount=4'hF, holding. The IR still updates on each pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Purpose : Shared constants and types for the fetch unit and the controller.
// Contents: PC / instruction widths, pc_t / instr_t, opcode field position.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_WIDTH    = 7;
    localparam int INSTR_WIDTH = 16;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

endpackage : cpu_pkg

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Purpose : Instruction-memory read bus between the fetch unit and the memory.
// Signals : ImemAddr - word address (driven by fetch unit)
//           ImemData - read data, combinational from ImemAddr (driven by memory)
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
    import cpu_pkg::*;

    pc_t    ImemAddr;
    instr_t ImemData;

    modport master (output ImemAddr, input  ImemData);
    modport slave  (input  ImemAddr, output ImemData);

endinterface : instruction_fetch_unit_if

// File: rtl/instruction_fetch_unit_pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Purpose : Program counter with clear / load / increment priority.
// Ports   : Clk, Rst (sync, active-high)
//           PCClr     - PC <= 0
//           PCLd      - PC <= PCLdValue
//           PCUp      - PC <= PC + 1 (wraps at 2^PC_WIDTH-1)
//           PC        - current program counter
// -----------------------------------------------------------------------------
module pc_register
    import cpu_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic PCClr,
    input  logic PCLd,
    input  pc_t  PCLdValue,
    input  logic PCUp,
    output pc_t  PC
);

    pc_t r_pc;

    // Priority: Rst > PCClr > PCLd > PCUp > hold. Increment wraps naturally.
    always_ff @(posedge Clk) begin
        if (Rst)        r_pc <= '0;
        else if (PCClr) r_pc <= '0;
        else if (PCLd)  r_pc <= PCLdValue;
        else if (PCUp)  r_pc <= r_pc + pc_t'(1);
    end

    assign PC = r_pc;

endmodule : pc_register

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Purpose : Holds PC and IR for the controller; drives the instruction-memory
//           address and captures the returned word on IRLd.
// Ports   : Clk, Rst (sync, active-high)
//           PCClr, PCUp, PCLd, PCLdValue - PC control strobes / jump target
//           IRLd       - capture imem.ImemData into IR
//           imem       - instruction-memory bus (master side)
//           PCOut      - current PC
//           IR         - held instruction
//           IRPC       - address IR was fetched from
//           IRValid    - IR loaded since last reset / clear
//           FetchCount - saturating count of IRLd events
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     PCClr,
    input  logic                     PCUp,
    input  logic                     PCLd,
    input  pc_t                      PCLdValue,
    input  logic                     IRLd,
    instruction_fetch_unit_if.master imem,
    output pc_t                      PCOut,
    output instr_t                   IR,
    output pc_t                      IRPC,
    output logic                     IRValid,
    output logic [CNT_WIDTH-1:0]     FetchCount
);

    pc_t                  w_pc;
    instr_t               r_ir;
    pc_t                  r_irpc;
    logic                 r_ir_valid;
    logic [CNT_WIDTH-1:0] r_fetch_cnt;

    pc_register u_pc_register (
        .Clk       (Clk),
        .Rst       (Rst),
        .PCClr     (PCClr),
        .PCLd      (PCLd),
        .PCLdValue (PCLdValue),
        .PCUp      (PCUp),
        .PC        (w_pc)
    );

    assign imem.ImemAddr = w_pc;
    assign PCOut         = w_pc;

    // IR and IRPC sample the pre-update PC, so a FETCH (IRLd+PCUp) leaves
    // IR = mem[n] with PC = n+1.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ir   <= '0;
            r_irpc <= '0;
        end else if (IRLd) begin
            r_ir   <= imem.ImemData;
            r_irpc <= w_pc;
        end
    end

    // A clear marks a program restart, so it invalidates IR even when a load
    // happens on the same edge.
    always_ff @(posedge Clk) begin
        if (Rst)        r_ir_valid <= 1'b0;
        else if (PCClr) r_ir_valid <= 1'b0;
        else if (IRLd)  r_ir_valid <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            r_fetch_cnt <= '0;
        else if (IRLd && (r_fetch_cnt != '1))
            r_fetch_cnt <= r_fetch_cnt + CNT_WIDTH'(1);
    end

    assign IR         = r_ir;
    assign IRPC       = r_irpc;
    assign IRValid    = r_ir_valid;
    assign FetchCount = r_fetch_cnt;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    localparam int CW = 4;

    logic         Clk = 1'b0;
    logic         Rst, PCClr, PCUp, PCLd, IRLd;
    pc_t          PCLdValue;
    pc_t          PCOut, IRPC;
    instr_t       IR;
    logic         IRValid;
    logic [CW-1:0] FetchCount;

    instr_t mem [0:127];

    int n_pass = 0;
    int n_total = 0;

    instruction_fetch_unit_if bus ();

    assign bus.ImemData = mem[bus.ImemAddr];

    instruction_fetch_unit #(.CNT_WIDTH(CW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .PCClr      (PCClr),
        .PCUp       (PCUp),
        .PCLd       (PCLd),
        .PCLdValue  (PCLdValue),
        .IRLd       (IRLd),
        .imem       (bus),
        .PCOut      (PCOut),
        .IR         (IR),
        .IRPC       (IRPC),
        .IRValid    (IRValid),
        .FetchCount (FetchCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         name;
        logic          rst, clr, up, ld, irld;
        pc_t           ldval;
        pc_t           e_pc;
        instr_t        e_ir;
        pc_t           e_irpc;
        logic          e_valid;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check_state(input string nm, input pc_t epc, input instr_t eir,
                               input pc_t eirpc, input logic ev, input logic [CW-1:0] ecnt);
        n_total++;
        if (PCOut === epc && bus.ImemAddr === epc && IR === eir && IRPC === eirpc &&
            IRValid === ev && FetchCount === ecnt) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h addr=%h ir=%h irpc=%h valid=%b cnt=%h, want pc=%h ir=%h irpc=%h valid=%b cnt=%h",
                     nm, PCOut, bus.ImemAddr, IR, IRPC, IRValid, FetchCount,
                     epc, eir, eirpc, ev, ecnt);
        end
    endtask

    task automatic drive(input logic rst, input logic clr, input logic up,
                         input logic ld, input pc_t ldval, input logic irld);
        Rst = rst; PCClr = clr; PCUp = up; PCLd = ld; PCLdValue = ldval; IRLd = irld;
    endtask

    initial begin
        pc_t           exp_pc;
        instr_t        exp_ir;
        pc_t           exp_irpc;
        logic [CW-1:0] exp_cnt;

        for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]      = 16'h2A13;
        mem[1]      = 16'h3124;
        mem[7'h7F]  = 16'hBEEF;

        //          name           rst clr up ld irld ldval   pc     ir        irpc   v  cnt
        vecs[0]  = '{"reset1",     1, 0, 1, 0, 1, 7'h00, 7'h00, 16'h0000, 7'h00, 0, 4'd0};
        vecs[1]  = '{"reset2",     1, 0, 1, 0, 1, 7'h00, 7'h00, 16'h0000, 7'h00, 0, 4'd0};
        vecs[2]  = '{"idle0",      0, 0, 0, 0, 0, 7'h00, 7'h00, 16'h0000, 7'h00, 0, 4'd0};
        vecs[3]  = '{"fetch1",     0, 0, 1, 0, 1, 7'h00, 7'h01, 16'h2A13, 7'h00, 1, 4'd1};
        vecs[4]  = '{"hold1a",     0, 0, 0, 0, 0, 7'h00, 7'h01, 16'h2A13, 7'h00, 1, 4'd1};
        vecs[5]  = '{"hold1b",     0, 0, 0, 0, 0, 7'h00, 7'h01, 16'h2A13, 7'h00, 1, 4'd1};
        vecs[6]  = '{"fetch2",     0, 0, 1, 0, 1, 7'h00, 7'h02, 16'h3124, 7'h01, 1, 4'd2};
        vecs[7]  = '{"jump7f",     0, 0, 0, 1, 0, 7'h7F, 7'h7F, 16'h3124, 7'h01, 1, 4'd2};
        vecs[8]  = '{"wrap_fetch", 0, 0, 1, 0, 1, 7'h00, 7'h00, 16'hBEEF, 7'h7F, 1, 4'd3};
        vecs[9]  = '{"prio_clr",   0, 1, 1, 1, 0, 7'h10, 7'h00, 16'hBEEF, 7'h7F, 0, 4'd3};
        vecs[10] = '{"prio_ld",    0, 0, 1, 1, 0, 7'h10, 7'h10, 16'hBEEF, 7'h7F, 0, 4'd3};
        vecs[11] = '{"ld_with_clr",0, 1, 0, 0, 1, 7'h00, 7'h00, 16'h1010, 7'h10, 0, 4'd4};
        vecs[12] = '{"ld_no_up",   0, 0, 0, 0, 1, 7'h00, 7'h00, 16'h2A13, 7'h00, 1, 4'd5};
        vecs[13] = '{"midrun_rst", 1, 0, 0, 0, 1, 7'h00, 7'h00, 16'h0000, 7'h00, 0, 4'd0};
        vecs[14] = '{"up_only",    0, 0, 1, 0, 0, 7'h00, 7'h01, 16'h0000, 7'h00, 0, 4'd0};

        drive(1, 0, 0, 0, 7'h00, 0);
        @(posedge Clk); #1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].up, vecs[i].ld, vecs[i].ldval, vecs[i].irld);
            @(posedge Clk); #1;
            check_state(vecs[i].name, vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_irpc,
                        vecs[i].e_valid, vecs[i].e_cnt);
        end

        // Saturation: 20 back-to-back fetches from PC=1 with a 4-bit counter.
        exp_pc   = 7'h01;
        exp_cnt  = '0;
        exp_ir   = 16'h0000;
        exp_irpc = 7'h00;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 7'h00, 1);
            @(posedge Clk); #1;
            exp_ir   = mem[exp_pc];
            exp_irpc = exp_pc;
            exp_pc   = exp_pc + pc_t'(1);
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            check_state($sformatf("sat_pulse%0d", i), exp_pc, exp_ir, exp_irpc, 1'b1, exp_cnt);
        end

        // IR stays stable through idle cycles; counter holds at all-ones.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 7'h00, 0);
            @(posedge Clk); #1;
            check_state($sformatf("sat_hold%0d", i), 7'h15, 16'h1014, 7'h14, 1'b1, 4'hF);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
